// File: rtl/layer0_feature_loader_pkg.sv
// Shared layer-0 parameter package.
// Holds the frame geometry defaults and the loader state encoding. The
// layer-0 neuron wrappers use the same geometry, so the packed vector
// width always matches on both sides.
package layer0_feature_loader_pkg;

    localparam int L0_NUM_FEATURES = 16;
    localparam int L0_FEAT_W       = 16;
    localparam int L0_IN_BITS      = 2;

    typedef enum logic [1:0] {
        L0_COLLECT = 2'd0,
        L0_FULL    = 2'd1,
        L0_DISCARD = 2'd2
    } l0_state_e;

    // Counter width that stays legal when a frame has a single feature.
    function automatic int l0_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer0_feature_loader_quant.sv
// layer0_quant: combinational feature quantizer.
// Converts one signed feature word into an IN_BITS code centred on
// 2^(IN_BITS-1). The offset is removed at FEAT_W+1 bits so that it cannot
// wrap, then the result is arithmetically shifted and clamped.
// Ports:
//   data_i  - signed feature word
//   code_o  - unsigned code in [0, 2^IN_BITS-1]
module layer0_quant
    import layer0_feature_loader_pkg::*;
#(
    parameter int                       FEAT_W  = L0_FEAT_W,
    parameter int                       IN_BITS = L0_IN_BITS,
    parameter int                       SHIFT   = 12,
    parameter logic signed [FEAT_W-1:0] OFFSET  = '0
) (
    input  logic [FEAT_W-1:0]  data_i,
    output logic [IN_BITS-1:0] code_o
);

    localparam logic signed [FEAT_W+1:0] HALF = (FEAT_W+2)'(2**(IN_BITS-1));
    localparam logic signed [FEAT_W+1:0] QMAX = (FEAT_W+2)'(2**IN_BITS - 1);

    logic signed [FEAT_W:0]   y;
    logic signed [FEAT_W:0]   s;
    logic signed [FEAT_W+1:0] q;

    assign y = $signed({data_i[FEAT_W-1], data_i}) - $signed({OFFSET[FEAT_W-1], OFFSET});
    assign s = y >>> SHIFT;
    // One extra bit so the recentring add cannot overflow before the clamp.
    assign q = $signed({s[FEAT_W], s}) + HALF;

    always_comb begin
        if (q[FEAT_W+1])   code_o = '0;
        else if (q > QMAX) code_o = '1;
        else               code_o = q[IN_BITS-1:0];
    end

endmodule

// File: rtl/layer0_feature_loader.sv
// layer0_feature_loader: assembles a stream of signed feature beats into one
// packed vector of quantized codes for the layer-0 neuron array.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - feature beat handshake
//   in_data, in_last     - feature word, final-beat marker
//   out_valid/out_ready  - packed vector handshake
//   out_data             - feature k at [k*IN_BITS +: IN_BITS], k=0 first beat
//   err_frame            - sticky frame-alignment error
//   err_count            - saturating count of dropped frames
// A frame is delivered only if in_last arrives exactly on beat NUM_FEATURES-1.
// A frame that completes while the output register is still occupied parks
// in the collect buffer (FULL) and input is stalled until the slot frees.
module layer0_feature_loader
    import layer0_feature_loader_pkg::*;
#(
    parameter int                       NUM_FEATURES = L0_NUM_FEATURES,
    parameter int                       FEAT_W       = L0_FEAT_W,
    parameter int                       IN_BITS      = L0_IN_BITS,
    parameter int                       SHIFT        = 12,
    parameter logic signed [FEAT_W-1:0] OFFSET       = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [FEAT_W-1:0]               in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_FEATURES*IN_BITS-1:0] out_data,
    output logic                            err_frame,
    output logic [7:0]                      err_count
);

    localparam int CNT_W = l0_cnt_w(NUM_FEATURES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FEATURES - 1);

    typedef logic [NUM_FEATURES-1:0][IN_BITS-1:0] frame_t;

    l0_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    frame_t             coll_q;
    frame_t             out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               err_frame_q;
    logic [7:0]         err_count_q;

    logic [IN_BITS-1:0] code;
    frame_t             frame_full;
    logic               accept, at_end, slot_free;
    logic               in_collect, good_last, short_err, long_err, frame_err;
    logic               load_out;

    layer0_quant #(
        .FEAT_W (FEAT_W),
        .IN_BITS(IN_BITS),
        .SHIFT  (SHIFT),
        .OFFSET (OFFSET)
    ) u_quant (
        .data_i(in_data),
        .code_o(code)
    );

    // ---------------- beat classification ----------------
    assign accept     = in_valid & in_ready;
    assign at_end     = (cnt_q == CNT_LAST);
    assign slot_free  = !out_valid_q || out_ready;
    assign in_collect = (state_q == L0_COLLECT) && accept;
    assign good_last  = in_collect &&  at_end &&  in_last;
    assign short_err  = in_collect && !at_end &&  in_last;
    assign long_err   = in_collect &&  at_end && !in_last;
    assign frame_err  = short_err || long_err;

    // Final beat bypasses the buffer so the frame lands in one cycle.
    always_comb begin
        frame_full = coll_q;
        frame_full[NUM_FEATURES-1] = code;
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= L0_COLLECT;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            L0_COLLECT: begin
                if (good_last && !slot_free) state_d = L0_FULL;
                else if (long_err)           state_d = L0_DISCARD;
            end
            L0_FULL: begin
                if (slot_free) state_d = L0_COLLECT;
            end
            L0_DISCARD: begin
                if (accept && in_last) state_d = L0_COLLECT;
            end
            default: state_d = L0_COLLECT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready = (state_q != L0_FULL);
    end

    // ---------------- datapath next state ----------------
    always_comb begin
        cnt_d = cnt_q;
        if (in_collect) begin
            // Any frame end (good or bad) and the long-frame overflow restart at 0.
            if (in_last || at_end) cnt_d = '0;
            else                   cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == L0_DISCARD) begin
            cnt_d = '0;
        end
    end

    assign load_out = (good_last && slot_free) || ((state_q == L0_FULL) && slot_free);

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (load_out) begin
            // In FULL the buffer already holds the complete parked frame.
            out_data_d  = (state_q == L0_FULL) ? coll_q : frame_full;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            err_frame_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (frame_err) begin
                err_frame_q <= 1'b1;
                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Collect buffer carries no reset; slots are always written before use.
    always_ff @(posedge clk) begin
        if (in_collect) coll_q[cnt_q] <= code;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign err_frame = err_frame_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_layer0_feature_loader.sv
module tb_layer0_feature_loader;

    localparam int N  = 16;
    localparam int OW = 32;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;
    logic          err_frame;
    logic [7:0]    err_count;

    layer0_feature_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err_frame(err_frame),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec  = 0;
    int nfail = 0;

    // ---------------- behavioural model ----------------
    logic [OW-1:0] exp_q[$];
    int            mframe[N];
    int            mcnt;
    bit            mdiscard;
    int            merr;
    int            ndeliv;
    logic [OW-1:0] last_out;
    bit            prev_stall;
    logic [OW-1:0] prev_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int quant(input logic [15:0] d);
        int y, s, q;
        y = int'($signed(d));
        s = y >>> 12;
        q = s + 2;
        if (q < 0) q = 0;
        if (q > 3) q = 3;
        return q;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        mcnt     = 0;
        mdiscard = 0;
        merr     = 0;
    endfunction

    // Apply the framing rules to one accepted beat.
    function automatic void model_accept(input logic [15:0] d, input logic l);
        logic [OW-1:0] v;
        if (mdiscard) begin
            if (l) mdiscard = 0;
            return;
        end
        mframe[mcnt] = quant(d);
        if (l && mcnt == N-1) begin
            v = '0;
            for (int k = 0; k < N; k++) v[2*k +: 2] = 2'(mframe[k]);
            exp_q.push_back(v);
            mcnt = 0;
        end else if (l) begin
            merr++;
            mcnt = 0;
        end else if (mcnt == N-1) begin
            merr++;
            mdiscard = 1;
            mcnt = 0;
        end else begin
            mcnt++;
        end
    endfunction

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_data", 64'(out_data), 64'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_frame: got %0h expected none at %0t", out_data, $time);
                end else begin
                    chk("frame_data", 64'(out_data), 64'(exp_q.pop_front()));
                end
                ndeliv++;
                last_out = out_data;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            chk("err_count", 64'(err_count), 64'((merr > 255) ? 255 : merr));
            chk("err_frame", 64'(err_frame), 64'(merr != 0));
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic beat(input logic [15:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            nvec++;
            nfail++;
            $display("FAIL beat_timeout: in_ready got 0 expected 1 at %0t", $time);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        model_accept(d, l);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int base, input int step, input int nbeats, input int last_at);
        for (int k = 0; k < nbeats; k++) beat(16'(base + k*step), (k == last_at));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] qv[5];
    int          d0;

    initial begin
        qv[0] = 16'h0000; qv[1] = 16'hFFFF; qv[2] = 16'h7FFF; qv[3] = 16'h8000; qv[4] = 16'h1000;
        ndeliv = 0; last_out = '0; prev_stall = 0; prev_data = '0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        model_reset();

        // Reset state
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_err_frame", 64'(err_frame), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Model pins: 0x0000,0xFFFF,0x7FFF,0x8000,0x1000 -> 2,1,3,0,3
        chk("model_q0", 64'(quant(qv[0])), 64'd2);
        chk("model_q1", 64'(quant(qv[1])), 64'd1);
        chk("model_q2", 64'(quant(qv[2])), 64'd3);
        chk("model_q3", 64'(quant(qv[3])), 64'd0);
        chk("model_q4", 64'(quant(qv[4])), 64'd3);

        // Quantization frame: the five probe words then zeros (code 2)
        for (int k = 0; k < N; k++) beat((k < 5) ? qv[k] : 16'h0000, (k == N-1));
        idle(2);
        chk("quant_frame", 64'(last_out), 64'hAAAA_AB36);

        // Streaming 0x1000*(k-8): k=0..6 -> 0, k=7 -> 1, k=8 -> 2, k=9..15 -> 3
        for (int k = 0; k < N-1; k++) beat(16'(32'h1000 * (k - 8)), 1'b0);
        chk("stream_pre_valid", 64'(out_valid), 64'd0);
        beat(16'h7000, 1'b1);
        chk("stream_lat1_valid", 64'(out_valid), 64'd1);
        chk("stream_data", 64'(out_data), 64'hFFFE_4000);
        idle(1);
        chk("stream_post_valid", 64'(out_valid), 64'd0);

        // Backpressure: two frames while out_ready is low
        d0 = ndeliv;
        out_ready = 1'b0;
        send_frame(0, 16'h0800, N, N-1);
        send_frame(16'h7FFF, -16'h0900, N, N-1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(4);
        chk("bp_delivered", 64'(ndeliv - d0), 64'd2);
        chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("bp_in_ready_back", 64'(in_ready), 64'd1);

        // Short frame: in_last on beat 5
        d0 = ndeliv;
        send_frame(16'h1234, 16'h0111, 6, 5);
        idle(3);
        chk("short_no_out", 64'(ndeliv - d0), 64'd0);
        chk("short_err_frame", 64'(err_frame), 64'd1);
        chk("short_err_count", 64'(err_count), 64'd1);
        send_frame(16'hC000, 16'h0700, N, N-1);
        idle(3);
        chk("short_next_frame", 64'(ndeliv - d0), 64'd1);

        // Long frame: 20 beats, in_last on beat 19
        d0 = ndeliv;
        send_frame(16'h2000, -16'h0400, 20, 19);
        idle(3);
        chk("long_no_out", 64'(ndeliv - d0), 64'd0);
        chk("long_err_count", 64'(err_count), 64'd2);
        send_frame(16'h9000, 16'h0A00, N, N-1);
        idle(3);
        chk("long_next_frame", 64'(ndeliv - d0), 64'd1);

        // Reset mid-frame with a frame held at the output
        out_ready = 1'b0;
        send_frame(16'h4000, 16'h0300, N, N-1);
        send_frame(16'h0100, 16'h0100, 10, -1);
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_err_frame", 64'(err_frame), 64'd0);
        chk("async_rst_err_count", 64'(err_count), 64'd0);
        model_reset();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        d0 = ndeliv;
        send_frame(-16'h6000, 16'h0C00, N, N-1);
        chk("post_rst_lat1", 64'(out_valid), 64'd1);
        idle(2);
        chk("post_rst_delivered", 64'(ndeliv - d0), 64'd1);
        chk("post_rst_err_frame", 64'(err_frame), 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
